// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read port: in-order word requests with req/ready, responses with rvalid.
// No internal latency; request holds while ready is low, rvalid responses cannot be stalled.
// mem_ready backpressures requests; the master never throttles responses (it reserves credit).
interface if_fetch_unit_if #(
  parameter int BIT_NUMBER = 32
);
  logic                  mem_req;
  logic [BIT_NUMBER-1:0] mem_addr;
  logic                  mem_ready;
  logic                  mem_rvalid;
  logic [BIT_NUMBER-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ready,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ready,
    output mem_rvalid,
    output mem_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Generic synchronous FIFO with flush; head is presented combinationally.
// Latency: a pushed entry is visible at dout the cycle after the push.
// Backpressure: push into a full FIFO / pop from an empty one is ignored; callers gate by count.
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_push = push && (count != DEPTH_C);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !clr) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// Fetch front end: owns fetch PC, issues in-order reads, buffers {PC+4, instr} for IF/ID.
// Latency: a word returned in cycle N is presented in N+1; branch redirect requests next cycle.
// Backpressure: freeze holds the head; requests stop when FIFO+in-flight reach depth. IF_FETCH_PERF_EN adds perf counters.
module if_fetch_unit #(
  parameter int                    BIT_NUMBER = 32,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [BIT_NUMBER-1:0] RESET_PC   = '0,
  parameter logic [BIT_NUMBER-1:0] NOP_INSTR  = 32'hE1A00000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  branch_taken,
  input  logic [BIT_NUMBER-1:0] branch_addr,
  if_fetch_unit_if.master       mem,
  output logic [BIT_NUMBER-1:0] pc,
  output logic [BIT_NUMBER-1:0] instruction,
  output logic                  valid
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_bubbles
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]           DEPTH_W = (CW+1)'(FIFO_DEPTH);
  localparam logic [BIT_NUMBER-1:0] WORD    = BIT_NUMBER'(4);

  typedef struct packed {
    logic [BIT_NUMBER-1:0] pc;
    logic [BIT_NUMBER-1:0] instr;
  } entry_t;

  logic [BIT_NUMBER-1:0] fetch_pc;
  logic [BIT_NUMBER-1:0] resp_pc;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         outstanding_nxt;
  logic [CW-1:0]         drop_cnt;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           inflight;
  logic                  fifo_empty;
  logic                  accept;
  logic                  rsp;
  logic                  dropping;
  logic                  push;
  logic                  pop;
  entry_t                push_entry;
  entry_t                head;

  // Words already buffered plus words still owed by memory can never exceed the FIFO.
  assign inflight     = (CW+1)'(fifo_count) + (CW+1)'(outstanding);
  assign mem.mem_req  = !rst && !branch_taken && (inflight < DEPTH_W);
  assign mem.mem_addr = fetch_pc;

  assign accept   = mem.mem_req && mem.mem_ready;
  assign rsp      = mem.mem_rvalid && !rst;
  assign dropping = rsp && (drop_cnt != '0);
  assign push     = rsp && !dropping && !branch_taken;
  assign pop      = valid && !freeze && !branch_taken;

  assign outstanding_nxt = outstanding + CW'(accept) - CW'(rsp);

  assign push_entry.pc    = resp_pc + WORD;
  assign push_entry.instr = mem.mem_rdata;

  fifo_sync #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (branch_taken),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign valid       = !fifo_empty;
  assign pc          = valid ? head.pc    : '0;
  assign instruction = valid ? head.instr : NOP_INSTR;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (branch_taken) begin
        // Everything still owed after this edge belongs to the abandoned path.
        fetch_pc <= branch_addr;
        resp_pc  <= branch_addr;
        drop_cnt <= outstanding_nxt;
      end else begin
        if (accept)   fetch_pc <= fetch_pc + WORD;
        if (push)     resp_pc  <= resp_pc + WORD;
        if (dropping) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

`ifdef IF_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (push && (perf_fetched != '1))             perf_fetched <= perf_fetched + 1'b1;
      if (!valid && !freeze && (perf_bubbles != '1)) perf_bubbles <= perf_bubbles + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with an in-order, fixed-latency instruction memory model.
module tb_if_fetch_unit;
  localparam int BN = 32;
  localparam logic [31:0] NOP = 32'hE1A00000;

  logic          clk = 1'b0;
  logic          rst;
  logic          freeze;
  logic          branch_taken;
  logic [BN-1:0] branch_addr;
  logic [BN-1:0] pc;
  logic [BN-1:0] instruction;
  logic          valid;
`ifdef IF_FETCH_PERF_EN
  logic [31:0]   perf_fetched;
  logic [31:0]   perf_bubbles;
`endif

  if_fetch_unit_if #(.BIT_NUMBER(BN)) mem_bus ();

  if_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .mem          (mem_bus),
    .pc           (pc),
    .instruction  (instruction),
    .valid        (valid)
`ifdef IF_FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_bubbles (perf_bubbles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } req_t;

  req_t q[$];
  int   cyc   = 0;
  int   lat   = 1;
  int   tests = 0;
  int   fails = 0;

  function automatic logic [31:0] word_at(logic [31:0] a);
    return 32'hA000_0000 | a;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: record the accept seen before the edge, then drive this cycle's response.
  task automatic step();
    logic        acc;
    logic        in_rst;
    logic [31:0] a;
    req_t        r;
    acc    = mem_bus.mem_req && mem_bus.mem_ready;
    a      = mem_bus.mem_addr;
    in_rst = rst;
    @(posedge clk);
    #1;
    cyc++;
    if (in_rst) begin
      q.delete();
    end else if (acc) begin
      r.due  = cyc - 1 + lat;
      r.addr = a;
      q.push_back(r);
    end
    mem_bus.mem_rvalid = 1'b0;
    mem_bus.mem_rdata  = '0;
    if (!in_rst && (q.size() > 0) && (q[0].due <= cyc)) begin
      mem_bus.mem_rvalid = 1'b1;
      mem_bus.mem_rdata  = word_at(q[0].addr);
      void'(q.pop_front());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst                = 1'b1;
    freeze             = 1'b0;
    branch_taken       = 1'b0;
    branch_addr        = '0;
    mem_bus.mem_ready  = 1'b1;
    mem_bus.mem_rvalid = 1'b0;
    mem_bus.mem_rdata  = '0;
    step();
    step();

    chk("rst_valid",   32'(valid), 32'd0);
    chk("rst_instr",   instruction, NOP);
    chk("rst_pc",      pc, 32'd0);
    chk("rst_req",     32'(mem_bus.mem_req), 32'd0);
    chk("rst_addr",    mem_bus.mem_addr, 32'd0);
`ifdef IF_FETCH_PERF_EN
    chk("rst_perf_fetched", perf_fetched, 32'd0);
    chk("rst_perf_bubbles", perf_bubbles, 32'd0);
`endif

    // Streaming, 1-cycle memory.
    rst = 1'b0;
    #1;
    chk("c0_req",  32'(mem_bus.mem_req), 32'd1);
    chk("c0_addr", mem_bus.mem_addr, 32'd0);
    step();
    chk("c1_nobypass_valid", 32'(valid), 32'd0);
    chk("c1_addr", mem_bus.mem_addr, 32'd4);
    step();
    chk("c2_valid", 32'(valid), 32'd1);
    chk("c2_pc",    pc, 32'd4);
    chk("c2_instr", instruction, 32'hA000_0000);
    chk("c2_addr",  mem_bus.mem_addr, 32'd8);
    step();
    for (int k = 0; k < 4; k++) begin
      chk("stream_pc",    pc, 32'd8 + 32'(4 * k));
      chk("stream_instr", instruction, 32'hA000_0004 + 32'(4 * k));
      step();
    end

    // Freeze: buffer fills to depth, head stays put.
    freeze = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("frz_valid", 32'(valid), 32'd1);
      chk("frz_pc",    pc, 32'd24);
      chk("frz_instr", instruction, 32'hA000_0014);
    end
    chk("frz_req",  32'(mem_bus.mem_req), 32'd0);
    chk("frz_addr", mem_bus.mem_addr, 32'd36);

    freeze = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step();
      chk("rel_valid", 32'(valid), 32'd1);
      chk("rel_pc",    pc, 32'd24 + 32'(4 * k));
      chk("rel_instr", instruction, 32'hA000_0014 + 32'(4 * k));
    end

    // Memory stall: address held, FIFO drains to NOP.
    mem_bus.mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_addr", mem_bus.mem_addr, 32'd48);
      if (i >= 3) begin
        chk("drain_valid", 32'(valid), 32'd0);
        chk("drain_instr", instruction, NOP);
        chk("drain_pc",    pc, 32'd0);
      end
      step();
    end
    chk("stall_end_valid", 32'(valid), 32'd0);
    mem_bus.mem_ready = 1'b1;
    step();
    chk("resume_nobypass", 32'(valid), 32'd0);
    step();
    chk("resume_valid", 32'(valid), 32'd1);
    chk("resume_pc",    pc, 32'd52);
    chk("resume_instr", instruction, 32'hA000_0030);

    // Reset with a full FIFO.
    freeze = 1'b1;
    repeat (6) step();
    chk("full_req", 32'(mem_bus.mem_req), 32'd0);
    chk("full_pc",  pc, 32'd52);
    rst = 1'b1;
    #1;
    chk("midrst_req", 32'(mem_bus.mem_req), 32'd0);
    step();
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_addr",  mem_bus.mem_addr, 32'd0);
    chk("midrst_pc",    pc, 32'd0);
    chk("midrst_instr", instruction, NOP);
    freeze = 1'b0;
    lat    = 3;
    rst    = 1'b0;
    #1;
    chk("postrst_req", 32'(mem_bus.mem_req), 32'd1);

    // Latency 3, two old-path words in flight, redirect to 0x100.
    step();
    chk("l3_valid", 32'(valid), 32'd0);
    chk("l3_addr",  mem_bus.mem_addr, 32'd4);
    step();
    branch_taken = 1'b1;
    branch_addr  = 32'h100;
    #1;
    chk("br1_req", 32'(mem_bus.mem_req), 32'd0);
    step();
    branch_taken = 1'b0;
    #1;
    chk("br1_next_req",   32'(mem_bus.mem_req), 32'd1);
    chk("br1_next_addr",  mem_bus.mem_addr, 32'h100);
    chk("br1_next_valid", 32'(valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("br1_drop_valid", 32'(valid), 32'd0);
    end
    step();
    chk("br1_valid", 32'(valid), 32'd1);
    chk("br1_pc",    pc, 32'h104);
    chk("br1_instr", instruction, 32'hA000_0100);

    // Redirect in the same cycle an old-path word returns.
    step();
    chk("br2_pre_pc", pc, 32'h108);
    branch_taken = 1'b1;
    branch_addr  = 32'h200;
    #1;
    chk("br2_req", 32'(mem_bus.mem_req), 32'd0);
    step();
    branch_taken = 1'b0;
    #1;
    chk("br2_next_valid", 32'(valid), 32'd0);
    chk("br2_next_addr",  mem_bus.mem_addr, 32'h200);
    chk("br2_next_req",   32'(mem_bus.mem_req), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("br2_drop_valid", 32'(valid), 32'd0);
    end
    step();
    chk("br2_valid", 32'(valid), 32'd1);
    chk("br2_pc",    pc, 32'h204);
    chk("br2_instr", instruction, 32'hA000_0200);

    // Back-to-back redirects.
    branch_taken = 1'b1;
    branch_addr  = 32'h300;
    step();
    chk("b2b_valid0", 32'(valid), 32'd0);
    chk("b2b_addr0",  mem_bus.mem_addr, 32'h300);
    branch_addr = 32'h400;
    step();
    branch_taken = 1'b0;
    #1;
    chk("b2b_addr1",  mem_bus.mem_addr, 32'h400);
    chk("b2b_req1",   32'(mem_bus.mem_req), 32'd1);
    chk("b2b_valid1", 32'(valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("b2b_drop_valid", 32'(valid), 32'd0);
    end
    step();
    chk("b2b_valid", 32'(valid), 32'd1);
    chk("b2b_pc",    pc, 32'h404);
    chk("b2b_instr", instruction, 32'hA000_0400);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
